uart_lcd_sequencer: RTL and testbench
=====================================

# uart_lcd_sequencer

Receives bytes from the UART receiver's completion-flag handshake and buffers them in a small FIFO. Runs the HD44780-style LCD power-up initialisation, then drives character and command writes on the 8-bit LCD bus with cycle-counted enable and settle timing. It owns cursor tracking across the 2x16 display, so a typed byte stream wraps onto line 2 and back to line 1. Sits between the UART receive path and the LCD pins, replacing ad-hoc direct byte-to-LCD forwarding.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 2.
- E_HIGH, 12: cycles `lcd_e` is held high (at least 1).
- T_CMD, 2500: settle cycles after every write except clear.
- T_CLEAR, 82000: settle cycles after the 0x01 clear command.
- T_POWERUP, 750000: idle cycles after reset before the first init command.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  reset, asynchronous and active-low.
- uart_data  in  8  received byte; valid while `rx_complete_flag` is high.
- rx_complete_flag  in  1  level from the UART; stays high until deleted.
- rx_complete_del_flag  out  1  one-cycle pulse: byte taken, UART clears its flag.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  tied 0 (write only).
- lcd_e  out  1  LCD enable strobe.
- lcd_data  out  8  LCD data bus.
- ready  out  1  high once the init sequence has completed.

## Operation
- Reset value of every output is 0. Reset clears the FIFO, sets the cursor to 0, clears `armed`, and puts the FSM in POWERUP. Reset mid-write drops `lcd_e` immediately and restarts the init sequence.
- Capture:
  - A byte is pushed when `rx_complete_flag`=1, `armed`=1 and the FIFO is not full.
  - On push: `rx_complete_del_flag` pulses the next cycle and `armed` clears.
  - `armed` sets again only when `rx_complete_flag` is sampled 0, so a lingering flag is never captured twice.
  - FIFO full: no pulse; the flag stays pending and is captured once a slot frees.
  - Push and pop in the same cycle are both legal when the FIFO is full.
- FSM states: POWERUP, INIT, IDLE, DECODE, SETUP, STROBE, HOLD, WAIT.
- POWERUP counts T_POWERUP cycles, then goes to INIT.
- INIT issues commands in order: 0x38, 0x0C, 0x06, 0x01. After the last settle, `ready`=1 and the FSM enters IDLE.
- IDLE pops one byte when the FIFO is non-empty and moves to DECODE.
- DECODE rules:
  - 0x0D (CR): write command 0x01 and reset the cursor to 0.
  - 0x20..0x7E: write data with RS=1.
    - Before the write, if cursor=16, first write command 0xC0.
    - Before the write, if cursor=0 and the previous write was a character at position 31, first write command 0x80.
    - After the data write, cursor = (cursor+1) mod 32.
  - Any other byte is discarded; the FSM returns to IDLE with no bus activity.
- One write is SETUP → STROBE → HOLD → WAIT:
  - SETUP (1 cycle): drive RS and data.
  - STROBE: `lcd_e`=1 for E_HIGH cycles.
  - HOLD (1 cycle): `lcd_e`=0; RS and data are unchanged.
  - WAIT: T_CMD or T_CLEAR cycles, then the next queued write, or IDLE.
- `lcd_rs` and `lcd_data` change only in SETUP. Between writes they keep their last value.
- Counter width is clog2 of the largest timing parameter. The cursor is 5 bits and wraps from 31 to 0.

## Timing
- One write, measured from SETUP entry to the next SETUP or IDLE: 2 + E_HIGH + T_settle cycles.
- The first `lcd_e` rise happens T_POWERUP+1 cycles after reset deassertion.
- Byte latency, flag high to the `lcd_e` rise of its data write, with the FIFO empty and the FSM in IDLE: 4 cycles (push, pop, DECODE, SETUP).
- `rx_complete_del_flag` is exactly 1 cycle wide and comes 1 cycle after the sampled flag.
- Throughput is bounded by the LCD timing, not by the FIFO.

## Structure
- Package `lcd_seq_pkg` holds:
  - the LCD command constants (FUNC_SET 0x38, DISP_ON 0x0C, ENTRY 0x06, CLEAR 0x01, LINE1 0x80, LINE2 0xC0, CR 0x0D);
  - the FSM state enum;
  - the init-ROM length.
- One sub-module, `byte_fifo` (DEPTH, width 8, synchronous, full/empty flags, same-cycle push and pop). The sequencer FSM, timing counter and cursor stay in the top module.

## Test plan
Run all scenarios with DEPTH=4, E_HIGH=2, T_CMD=4, T_CLEAR=10, T_POWERUP=20.
- Release reset → four `lcd_e` pulses with data 0x38, 0x0C, 0x06, 0x01, all RS=0. The first `lcd_e` rise is at cycle 21. `ready` rises after the 10-cycle clear settle.
- After ready, hold flag high with 0x41 until the del pulse → exactly one del pulse and one RS=1 write of 0x41. A flag held 3 extra cycles produces no second capture.
- Send 17 printable bytes 0x30..0x40 → the 17th data write is preceded by command 0xC0. Send 15 more, then one more → command 0x80 precedes the 33rd character.
- Send 0x0D → command 0x01 followed by a 10-cycle settle. The next character writes with no 0xC0 or 0x80 before it (cursor is 0).
- Send 6 bytes back-to-back during a write → 4 are captured immediately. The 5th is del-pulsed only after the first pop. All 6 appear on the bus in order.
- Assert reset_n low while in STROBE → `lcd_e`, `lcd_rs`, `lcd_data`, `ready` and `rx_complete_del_flag` are all 0 in the same cycle. After release, INIT re-runs from 0x38.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared constants, FSM state encoding and init ROM for the UART-to-LCD sequencer.
package lcd_seq_pkg;

    // HD44780 command bytes and the carriage-return control character
    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;
    localparam logic [7:0] CR       = 8'h0D;

    // Power-up init sequence length and the index width that can also hold "done"
    localparam int unsigned INIT_LEN   = 4;
    localparam int unsigned INIT_IDX_W = 3;

    // FSM state encoding
    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;
    localparam logic [2:0] ST_POWERUP = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_IDLE    = 3'd2;
    localparam logic [2:0] ST_DECODE  = 3'd3;
    localparam logic [2:0] ST_SETUP   = 3'd4;
    localparam logic [2:0] ST_STROBE  = 3'd5;
    localparam logic [2:0] ST_HOLD    = 3'd6;
    localparam logic [2:0] ST_WAIT    = 3'd7;

    // Init ROM: command issued at each step of the power-up sequence
    function automatic logic [7:0] init_cmd(input logic [INIT_IDX_W-1:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = FUNC_SET;
            3'd1:    cmd = DISP_ON;
            3'd2:    cmd = ENTRY;
            default: cmd = CLEAR;
        endcase
        return cmd;
    endfunction

    // Printable ASCII range accepted as display characters
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a show-ahead head word.
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push_c, do_pop_c;

    // A push is accepted when a slot is free or one is being freed this cycle
    always_comb begin
        do_push_c = push_i && (!full_q || pop_i);
        do_pop_c  = pop_i && !empty_q;
        count_d   = count_q;
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push_c) wptr_q <= wptr_q + AW'(1);
            if (do_pop_c)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage array (no reset needed; guarded by the occupancy count)
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_lcd_sequencer.sv
// Buffers UART bytes, runs LCD power-up init and drives timed LCD writes with cursor wrap.
module uart_lcd_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned E_HIGH    = 12,
    parameter int unsigned T_CMD     = 2500,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_POWERUP = 750000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] uart_data,
    input  logic       rx_complete_flag,
    output logic       rx_complete_del_flag,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       ready
);

    localparam int unsigned T_MAX1 = (E_HIGH > T_CMD) ? E_HIGH : T_CMD;
    localparam int unsigned T_MAX2 = (T_CLEAR > T_POWERUP) ? T_CLEAR : T_POWERUP;
    localparam int unsigned T_MAX  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
    localparam int unsigned CNT_W  = $clog2(T_MAX);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, settle_c;
    logic [4:0]            cursor_q, cursor_d;
    logic                  last31_q, last31_d;
    logic [INIT_IDX_W-1:0] init_idx_q, init_idx_d;
    logic [7:0]            byte_q, byte_d;
    logic [7:0]            pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  lcd_rs_q, lcd_rs_d;
    logic [7:0]            lcd_data_q, lcd_data_d;
    logic                  lcd_e_q, lcd_e_d;
    logic                  ready_q, ready_d;
    logic                  armed_q, armed_d;
    logic                  del_q;
    logic                  push_c, pop_c;
    logic                  fifo_full, fifo_empty;
    logic [7:0]            fifo_head;

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_c),
        .wdata_i (uart_data),
        .pop_i   (pop_c),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Capture handshake: one push per flag assertion, re-armed only by a low flag
    always_comb begin
        push_c  = rx_complete_flag && armed_q && (!fifo_full || pop_c);
        armed_d = armed_q;
        if (push_c) begin
            armed_d = 1'b0;
        end else if (!rx_complete_flag) begin
            armed_d = 1'b1;
        end
    end

    // Sequencer next-state, write scheduling and cursor tracking
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cursor_d   = cursor_q;
        last31_d   = last31_q;
        init_idx_d = init_idx_q;
        byte_d     = byte_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        ready_d    = ready_q;
        pop_c      = 1'b0;
        settle_c   = (!lcd_rs_q && (lcd_data_q == CLEAR)) ? CNT_W'(T_CLEAR - 1)
                                                          : CNT_W'(T_CMD - 1);

        case (state_q)
            ST_POWERUP: begin
                // INIT takes the last idle cycle before the first SETUP
                if (cnt_q == CNT_W'(T_POWERUP - 2)) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_INIT: begin
                lcd_rs_d   = 1'b0;
                lcd_data_d = init_cmd(init_idx_q);
                init_idx_d = init_idx_q + INIT_IDX_W'(1);
                state_d    = ST_SETUP;
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    byte_d  = fifo_head;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (byte_q == CR) begin
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = CLEAR;
                    cursor_d   = '0;
                    last31_d   = 1'b0;
                    state_d    = ST_SETUP;
                end else if (is_printable(byte_q)) begin
                    state_d = ST_SETUP;
                    if ((cursor_q == 5'd16) || ((cursor_q == 5'd0) && last31_q)) begin
                        // Reposition first; the character follows from WAIT
                        lcd_rs_d   = 1'b0;
                        lcd_data_d = (cursor_q == 5'd16) ? LINE2 : LINE1;
                        pend_d     = byte_q;
                        pend_vld_d = 1'b1;
                    end else begin
                        lcd_rs_d   = 1'b1;
                        lcd_data_d = byte_q;
                        last31_d   = (cursor_q == 5'd31);
                        cursor_d   = cursor_q + 5'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
            end
            ST_STROBE: begin
                if (cnt_q == CNT_W'(E_HIGH - 1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == settle_c) begin
                    cnt_d = '0;
                    if (!ready_q) begin
                        if (init_idx_q == INIT_IDX_W'(INIT_LEN)) begin
                            ready_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            lcd_rs_d   = 1'b0;
                            lcd_data_d = init_cmd(init_idx_q);
                            init_idx_d = init_idx_q + INIT_IDX_W'(1);
                            state_d    = ST_SETUP;
                        end
                    end else if (pend_vld_q) begin
                        lcd_rs_d   = 1'b1;
                        lcd_data_d = pend_q;
                        pend_vld_d = 1'b0;
                        last31_d   = (cursor_q == 5'd31);
                        cursor_d   = cursor_q + 5'd1;
                        state_d    = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_POWERUP;
                cnt_d   = '0;
            end
        endcase

        lcd_e_d = (state_d == ST_STROBE);
    end

    // State, timing and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_POWERUP;
            cnt_q      <= '0;
            cursor_q   <= '0;
            last31_q   <= 1'b0;
            init_idx_q <= '0;
            byte_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
            lcd_e_q    <= 1'b0;
            ready_q    <= 1'b0;
            armed_q    <= 1'b0;
            del_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cursor_q   <= cursor_d;
            last31_q   <= last31_d;
            init_idx_q <= init_idx_d;
            byte_q     <= byte_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            lcd_e_q    <= lcd_e_d;
            ready_q    <= ready_d;
            armed_q    <= armed_d;
            del_q      <= push_c;
        end
    end

    assign rx_complete_del_flag = del_q;
    assign lcd_rs               = lcd_rs_q;
    assign lcd_rw               = 1'b0;
    assign lcd_e                = lcd_e_q;
    assign lcd_data             = lcd_data_q;
    assign ready                = ready_q;

endmodule

// File: tb/tb_uart_lcd_sequencer.sv
// Scoreboard bench: expected LCD writes are queued when bytes are sent and popped on each lcd_e rise.
module tb_uart_lcd_sequencer;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned E_HIGH    = 2;
    localparam int unsigned T_CMD     = 4;
    localparam int unsigned T_CLEAR   = 10;
    localparam int unsigned T_POWERUP = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] uart_data;
    logic       rx_complete_flag;
    logic       rx_complete_del_flag;
    logic       lcd_rs, lcd_rw, lcd_e, ready;
    logic [7:0] lcd_data;

    uart_lcd_sequencer #(
        .DEPTH     (DEPTH),
        .E_HIGH    (E_HIGH),
        .T_CMD     (T_CMD),
        .T_CLEAR   (T_CLEAR),
        .T_POWERUP (T_POWERUP)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .uart_data            (uart_data),
        .rx_complete_flag     (rx_complete_flag),
        .rx_complete_del_flag (rx_complete_del_flag),
        .lcd_rs               (lcd_rs),
        .lcd_rw               (lcd_rw),
        .lcd_e                (lcd_e),
        .lcd_data             (lcd_data),
        .ready                (ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;
    logic [8:0] exp_q[$];
    int rises[$];
    int dels[$];
    int n_c0 = 0;
    int n_80 = 0;
    int m_cur = 0;
    bit m_last31 = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc - rel);
        end
    endtask

    // Reference display model: what the LCD bus must show for each byte sent
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0D) begin
            exp_q.push_back({1'b0, 8'h01});
            m_cur    = 0;
            m_last31 = 1'b0;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            if (m_cur == 16) exp_q.push_back({1'b0, 8'hC0});
            else if (m_cur == 0 && m_last31) exp_q.push_back({1'b0, 8'h80});
            exp_q.push_back({1'b1, b});
            m_last31 = (m_cur == 31);
            m_cur    = (m_cur + 1) % 32;
        end
    endtask

    // Bus monitor: scoreboard pop on lcd_e rise, strobe width and hold checks
    initial begin : monitor
        logic       e_prev = 1'b0;
        logic       del_prev = 1'b0;
        int         e_len = 0;
        logic [8:0] rise_word = '0;
        logic [8:0] exp;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (lcd_e && !e_prev) begin
                rises.push_back(cyc - rel);
                rise_word = {lcd_rs, lcd_data};
                if (!lcd_rs && lcd_data == 8'hC0) n_c0++;
                if (!lcd_rs && lcd_data == 8'h80) n_80++;
                if (exp_q.size() == 0) begin
                    check("bus_extra_write", {23'd0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("bus_write", {23'd0, lcd_rs, lcd_data}, {23'd0, exp});
                    check("lcd_rw", {31'd0, lcd_rw}, 32'd0);
                end
            end
            if (!lcd_e && e_prev && reset_n) begin
                check("e_width", e_len, E_HIGH);
                check("hold_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, rise_word});
            end
            e_len = lcd_e ? e_len + 1 : 0;
            if (rx_complete_del_flag) begin
                check("del_width", {31'd0, del_prev}, 32'd0);
                dels.push_back(cyc - rel);
            end
            e_prev   = lcd_e;
            del_prev = rx_complete_del_flag;
        end
    end

    // Release reset, expect the four init commands and timing, wait for ready
    task automatic do_init();
        int rdy_cyc;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        rises.delete();
        dels.delete();
        rdy_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (ready) begin
                rdy_cyc = cyc - rel;
                break;
            end
        end
        check("ready_seen", {31'd0, ready}, 32'd1);
        check("ready_cycle", rdy_cyc, T_POWERUP + 1 + 3 * (2 + E_HIGH + T_CMD) + E_HIGH + 1 + T_CLEAR);
        check("init_writes", rises.size(), 4);
        if (rises.size() >= 4) begin
            check("first_e_rise", rises[0], T_POWERUP + 1);
            for (int k = 1; k < 4; k++) check("init_period", rises[k] - rises[k-1], 2 + E_HIGH + T_CMD);
        end
    endtask

    // UART model: raise flag with a byte, drop it after the del pulse (optionally late)
    task automatic send_byte(input logic [7:0] b, input int extra, output int t_raise, output int t_del);
        model_byte(b);
        uart_data        = b;
        rx_complete_flag = 1'b1;
        t_raise          = cyc - rel;
        t_del            = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (rx_complete_del_flag) begin
                t_del = cyc - rel;
                break;
            end
        end
        if (t_del < 0) check("del_timeout", {31'd0, rx_complete_del_flag}, 32'd1);
        repeat (extra) begin
            @(posedge clk);
            #2;
        end
        rx_complete_flag = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check("drain", exp_q.size(), 0);
        repeat (T_CLEAR + 10) @(posedge clk);
        #2;
    endtask

    initial begin : stim
        int tr, td, ri, nd, cr_rise, del4, del5;
        reset_n          = 1'b0;
        uart_data        = 8'h00;
        rx_complete_flag = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_del", {31'd0, rx_complete_del_flag}, 32'd0);

        do_init();

        // Single byte with a lingering flag: one capture, 4-cycle latency
        ri = rises.size();
        nd = dels.size();
        send_byte(8'h41, 3, tr, td);
        drain();
        check("single_capture", dels.size() - nd, 1);
        check("del_latency", td - tr, 1);
        if (rises.size() > ri) check("byte_latency", rises[ri] - tr, 4);

        // Line-2 wrap on the 17th character, line-1 wrap after position 31
        for (int i = 0; i < 17; i++) send_byte(8'(8'h30 + i), 0, tr, td);
        drain();
        check("line2_cmd_count", n_c0, 1);
        check("line1_cmd_count", n_80, 0);
        for (int i = 0; i < 15; i++) send_byte(8'(8'h50 + i), 0, tr, td);
        send_byte(8'h7E, 0, tr, td);
        drain();
        check("line1_after_wrap", n_80, 1);

        // CR followed by a 6-byte burst during the clear write
        ri = rises.size();
        send_byte(8'h0D, 0, tr, td);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h61 + i), 0, tr, td);
            if (i == 3) del4 = td;
            if (i == 4) del5 = td;
        end
        drain();
        check("no_prefix_after_cr", n_c0 + n_80, 2);
        check("burst_writes", rises.size() - ri, 7);
        if (rises.size() >= ri + 7) begin
            cr_rise = rises[ri];
            check("four_fast_captures", {31'd0, del4 < cr_rise + int'(E_HIGH) + 2 + int'(T_CLEAR)}, 32'd1);
            check("fifth_after_pop", del5 - cr_rise, E_HIGH + 2 + T_CLEAR);
            check("clear_settle", rises[ri+1] - rises[ri], E_HIGH + T_CLEAR + 4);
            for (int k = 1; k < 6; k++) check("char_period", rises[ri+k+1] - rises[ri+k], E_HIGH + T_CMD + 4);
        end

        // Reset while lcd_e is high
        send_byte(8'h5A, 0, tr, td);
        for (int i = 0; i < 100; i++) begin
            if (lcd_e) break;
            @(posedge clk);
            #2;
        end
        check("strobe_reached", {31'd0, lcd_e}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("mid_rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
        check("mid_rst_lcd_data", {24'd0, lcd_data}, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        check("mid_rst_del", {31'd0, rx_complete_del_flag}, 32'd0);
        exp_q.delete();
        m_cur    = 0;
        m_last31 = 1'b0;
        repeat (2) @(posedge clk);
        do_init();

        send_byte(8'h42, 0, tr, td);
        drain();
        check("final_ready", {31'd0, ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
